// File: rtl/ps2_feed_arbiter.sv
// Round-robin feeder that merges two scancode producers onto the keyboard block's
// write port, pacing bytes with a credit count so the keyboard ring never overruns.
module ps2_feed_arbiter #(
  parameter int         DEPTH = 16,
  parameter logic [9:0] ADDR  = 10'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [7:0]  a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [7:0]  b_data,
  output logic        b_ready,
  output logic [9:0]  m_addr,
  output logic [31:0] m_din,
  output logic [3:0]  m_lane,
  output logic        m_wr,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic        kbd_ack,
  input  logic        flush,
  output logic [4:0]  inflight,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DROP} state_t;

  localparam logic [4:0] CAP = 5'(DEPTH - 1);

  state_t     state_reg, state_next;
  logic       a_ready_reg, a_ready_next;
  logic       b_ready_reg, b_ready_next;
  logic       last_b_reg, last_b_next;
  logic [7:0] din_reg, din_next;
  logic [4:0] inflight_reg, inflight_next;
  logic       pick_a;
  logic       deliver;
  logic       ack_take;

  always_comb begin
    state_next   = state_reg;
    a_ready_next = 1'b0;
    b_ready_next = 1'b0;
    last_b_next  = last_b_reg;
    din_next     = din_reg;
    pick_a       = 1'b0;
    deliver      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!flush && (a_valid || b_valid) && (inflight_reg < CAP)) begin
          // On a tie the requester that lost last time wins.
          pick_a       = a_valid && (!b_valid || last_b_reg);
          a_ready_next = pick_a;
          b_ready_next = !pick_a;
          last_b_next  = !pick_a;
          din_next     = pick_a ? a_data : b_data;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_next = IDLE;
        end else if (m_ready) begin
          deliver    = 1'b1;
          state_next = DROP;
        end
      end
      DROP: begin
        // The keyboard block writes on valid & ~ready, so valid must fall for a cycle.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    ack_take = kbd_ack && (inflight_reg != 5'd0);
    if (flush) begin
      inflight_next = 5'd0;
    end else if (deliver && !ack_take && (inflight_reg < CAP)) begin
      inflight_next = inflight_reg + 5'd1;
    end else if (!deliver && ack_take) begin
      inflight_next = inflight_reg - 5'd1;
    end else begin
      inflight_next = inflight_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      a_ready_reg  <= 1'b0;
      b_ready_reg  <= 1'b0;
      last_b_reg   <= 1'b1;
      din_reg      <= 8'h00;
      inflight_reg <= 5'd0;
    end else begin
      state_reg    <= state_next;
      a_ready_reg  <= a_ready_next;
      b_ready_reg  <= b_ready_next;
      last_b_reg   <= last_b_next;
      din_reg      <= din_next;
      inflight_reg <= inflight_next;
    end
  end

  assign a_ready  = a_ready_reg;
  assign b_ready  = b_ready_reg;
  assign m_addr   = ADDR;
  assign m_din    = {24'h000000, din_reg};
  assign m_lane   = 4'b0001;
  assign m_wr     = 1'b1;
  assign m_valid  = (state_reg == ISSUE);
  assign inflight = inflight_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: doc/ps2_feed_arbiter.md
# ps2_feed_arbiter

Shares the keyboard scancode injection port between two byte producers (A: RISC-V host path, B: auxiliary source such as a typematic generator). Round-robin arbitration selects one byte at a time and drives the keyboard block's write handshake. Credit-based pacing limits bytes in flight so the keyboard's 16-entry ring never overruns; an overrun would silently drop the oldest scancode. Sits between the producers and the keyboard block on the RISC-V side of the design.

## Interface

Parameters:
- DEPTH, 16, keyboard ring size; usable capacity is DEPTH-1.
- ADDR, 10'h000, constant value driven on m_addr.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid, b_valid  in  1  requester has a byte; held until its ready pulse.
- a_data, b_data  in  8  scancode byte; stable while valid.
- a_ready, b_ready  out  1  one-cycle accept pulse to requester.
- m_addr  out  10  = ADDR.
- m_din  out  32  {24'h0, granted byte}.
- m_lane  out  4  = 4'b0001.
- m_wr  out  1  = 1.
- m_valid  out  1  write request to keyboard block.
- m_ready  in  1  keyboard block accept.
- kbd_ack  in  1  one-cycle pulse each time the guest CPU pops a byte (port 61h bit7 low with ring non-empty).
- flush  in  1  synchronous; clears credits and aborts pending grant.
- inflight  out  5  bytes believed resident in keyboard ring.
- busy  out  1  high when state != IDLE.

## Operation

- FSM states: IDLE, ISSUE, DROP.
- IDLE: if inflight < DEPTH-1 and any valid, grant. Both valid: grant requester not granted last time (last_grant reset = B, so A wins first tie). Latch byte into m_din, pulse granted requester's ready in the same cycle, go ISSUE.
- ISSUE: m_valid=1. On m_ready=1: inflight+1, go DROP.
- DROP: m_valid=0 for exactly one cycle, go IDLE. Required because the keyboard block writes on valid & ~ready and keeps ready high while valid remains high.
- Credits: delivery and kbd_ack in same cycle -> inflight unchanged. kbd_ack with inflight=0 ignored (no underflow). inflight never exceeds DEPTH-1.
- flush: inflight<=0; if in ISSUE, m_valid drops next cycle and byte is discarded (already acknowledged to requester); go IDLE. flush has priority over all other updates.
- Requesters not granted see no ready; they keep valid asserted.
- last_grant updates only on grant.

## Timing

- Reset values: a_ready=b_ready=0, m_valid=0, m_din=0, inflight=0, busy=0, state=IDLE, last_grant=B.
- Grant: ready pulse and m_din load in cycle N (registered, visible N+1); m_valid high from N+1.
- Keyboard block asserts m_ready one cycle after valid unless stalled by a 61h ack; hold m_valid indefinitely until m_ready.
- Best-case throughput: one byte per 4 cycles (IDLE, ISSUE, ISSUE-ack, DROP).
- inflight updates the cycle after m_ready/kbd_ack sample; IDLE grant decision uses registered inflight.
- reset_n low mid-transfer: all outputs to reset values immediately; byte lost.

## Test plan

- Single byte: a_valid with a_data=8'h1C -> a_ready pulse one cycle, m_valid high, m_din=32'h1C until m_ready, then m_valid low one cycle, inflight=1.
- Tie: a_valid and b_valid continuously, data 8'h11/8'h22 -> delivered order 11,22,11,22; each ready pulses once per delivery.
- Credit stop: 15 bytes from A with no kbd_ack -> inflight=15, 16th byte not granted (a_ready stays 0); one kbd_ack -> 16th delivered, inflight back to 15.
- Simultaneous: kbd_ack in same cycle as m_ready with inflight=5 -> inflight stays 5; kbd_ack at inflight=0 -> stays 0.
- Stall: hold m_ready low 10 cycles in ISSUE -> m_valid and m_din stable throughout, no second grant.
- flush during ISSUE with inflight=7 -> next cycle m_valid=0, inflight=0, state IDLE; async reset_n pulse mid-ISSUE -> all outputs at reset values.
